// File: rtl/stepper_pkg.sv
// +------------------------------------------------------------+
// | stepper_pkg: coil phase patterns, decode helper, FSM types |
// | rev 1.0                                                    |
// +------------------------------------------------------------+
`default_nettype none

package stepper_pkg;

   localparam int COIL_W = 4;

   localparam logic [3:0] PHASE_0    = 4'b0100;
   localparam logic [3:0] PHASE_1    = 4'b0101;
   localparam logic [3:0] PHASE_2    = 4'b0001;
   localparam logic [3:0] PHASE_3    = 4'b1001;
   localparam logic [3:0] PHASE_4    = 4'b1000;
   localparam logic [3:0] PHASE_5    = 4'b1010;
   localparam logic [3:0] PHASE_6    = 4'b0010;
   localparam logic [3:0] PHASE_7    = 4'b0110;
   localparam logic [3:0] PHASE_IDLE = 4'b0000;

   localparam logic [1:0] FAULT_NONE    = 2'b00;
   localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
   localparam logic [1:0] FAULT_SKIP    = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TRACK = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   typedef struct packed {
      logic       valid;
      logic       idle;
      logic [2:0] index;
   } phase_t;

   function automatic phase_t decode_phase(input logic [3:0] pattern);
      phase_t d;
      d.valid = 1'b0;
      d.idle  = 1'b0;
      d.index = 3'd0;
      case (pattern)
         PHASE_0:    begin d.valid = 1'b1; d.index = 3'd0; end
         PHASE_1:    begin d.valid = 1'b1; d.index = 3'd1; end
         PHASE_2:    begin d.valid = 1'b1; d.index = 3'd2; end
         PHASE_3:    begin d.valid = 1'b1; d.index = 3'd3; end
         PHASE_4:    begin d.valid = 1'b1; d.index = 3'd4; end
         PHASE_5:    begin d.valid = 1'b1; d.index = 3'd5; end
         PHASE_6:    begin d.valid = 1'b1; d.index = 3'd6; end
         PHASE_7:    begin d.valid = 1'b1; d.index = 3'd7; end
         PHASE_IDLE: d.idle = 1'b1;
         default:    ;
      endcase
      return d;
   endfunction

endpackage

`default_nettype wire

// File: rtl/stepper_phase_monitor_phase_sync_filter.sv
// +------------------------------------------------------------+
// | phase_sync_filter: 2-flop synchronizer + stability filter  |
// | rev 1.0                                                    |
// +------------------------------------------------------------+
`default_nettype none

module phase_sync_filter #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           restart,
   input  logic [stepper_pkg::COIL_W-1:0] coil,
   output logic [stepper_pkg::COIL_W-1:0] accepted,
   output logic                           accept
);
   import stepper_pkg::*;

   localparam int               CNT_W   = $clog2(STABLE_CYCLES + 2);
   localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(STABLE_CYCLES);

   logic [COIL_W-1:0] sync1;
   logic [COIL_W-1:0] sync2;
   logic [COIL_W-1:0] cand;
   logic [CNT_W-1:0]  run_cnt;
   logic [CNT_W-1:0]  run_next;
   logic              have_accepted;

   // Length of the current run of identical synchronized samples, including this one.
   always_comb begin
      run_next = (sync2 == cand) ? run_cnt + CNT_W'(1) : CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1         <= '0;
         sync2         <= '0;
         cand          <= '0;
         run_cnt       <= '0;
         accepted      <= '0;
         accept        <= 1'b0;
         have_accepted <= 1'b0;
      end else begin
         sync1  <= coil;
         sync2  <= sync1;
         cand   <= sync2;
         accept <= 1'b0;
         if (restart) begin
            run_cnt       <= '0;
            have_accepted <= 1'b0;
         end else begin
            run_cnt <= (run_next > RUN_MAX) ? RUN_MAX : run_next;
            // Exact match fires once per run; saturation keeps it from re-firing.
            if (run_next == RUN_MAX && !(have_accepted && sync2 == accepted)) begin
               accepted      <= sync2;
               have_accepted <= 1'b1;
               accept        <= 1'b1;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/stepper_phase_monitor.sv
// +------------------------------------------------------------+
// | stepper_phase_monitor: coil phases -> position/period/fault|
// | rev 1.0                                                    |
// +------------------------------------------------------------+
`default_nettype none

module stepper_phase_monitor #(
   parameter int STABLE_CYCLES = 4,
   parameter int POS_W         = 32,
   parameter int PER_W         = 24
) (
   input  logic             CLK50MHZ,
   input  logic             resetn,
   input  logic [3:0]       coil,
   input  logic             pos_clear,
   input  logic             fault_clear,
   output logic [POS_W-1:0] position,
   output logic             step_pulse,
   output logic             step_dir,
   output logic [PER_W-1:0] step_period,
   output logic             period_valid,
   output logic             fault,
   output logic [1:0]       fault_code,
   output logic             tracking
);
   import stepper_pkg::*;

   localparam logic [PER_W-1:0] PER_MAX = '1;

   state_t     state;
   state_t     state_next;
   logic       restart;
   logic       accept;
   logic [3:0] accepted;
   phase_t     dec;
   logic [2:0] phase_idx;
   logic [2:0] delta;
   logic       acquire;
   logic       do_step;
   logic       step_rev;
   logic [1:0] code_next;
   logic [PER_W-1:0] per_cnt;
   logic       step_seen;

   assign restart  = fault_clear && (state == ST_FAULT);
   assign fault    = (state == ST_FAULT);
   assign tracking = (state == ST_TRACK);

   phase_sync_filter #(
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_filter (
      .clk      (CLK50MHZ),
      .rst_n    (resetn),
      .restart  (restart),
      .coil     (coil),
      .accepted (accepted),
      .accept   (accept)
   );

   always_ff @(posedge CLK50MHZ or negedge resetn) begin
      if (!resetn) state <= ST_IDLE;
      else         state <= state_next;
   end

   always_comb begin
      dec        = decode_phase(accepted);
      delta      = dec.index - phase_idx;
      state_next = state;
      acquire    = 1'b0;
      do_step    = 1'b0;
      step_rev   = 1'b0;
      code_next  = FAULT_NONE;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (dec.valid) begin
                  state_next = ST_TRACK;
                  acquire    = 1'b1;
               end else if (!dec.idle) begin
                  state_next = ST_FAULT;
                  code_next  = FAULT_ILLEGAL;
               end
            end
         end
         ST_TRACK: begin
            if (accept) begin
               if (dec.idle) begin
                  state_next = ST_IDLE;
               end else if (!dec.valid) begin
                  state_next = ST_FAULT;
                  code_next  = FAULT_ILLEGAL;
               end else if (delta == 3'd1) begin
                  do_step = 1'b1;
               end else if (delta == 3'd7) begin
                  do_step  = 1'b1;
                  step_rev = 1'b1;
               end else if (delta != 3'd0) begin
                  state_next = ST_FAULT;
                  code_next  = FAULT_SKIP;
               end
            end
         end
         ST_FAULT: begin
            if (fault_clear) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK50MHZ or negedge resetn) begin
      if (!resetn) begin
         position     <= '0;
         step_pulse   <= 1'b0;
         step_dir     <= 1'b0;
         step_period  <= '0;
         period_valid <= 1'b0;
         fault_code   <= FAULT_NONE;
         phase_idx    <= 3'd0;
         per_cnt      <= '0;
         step_seen    <= 1'b0;
      end else begin
         step_pulse <= do_step;
         if (do_step) step_dir <= step_rev;
         if (do_step || acquire) phase_idx <= dec.index;

         if (pos_clear)    position <= '0;
         else if (do_step) position <= step_rev ? position - POS_W'(1) : position + POS_W'(1);

         if (code_next != FAULT_NONE) fault_code <= code_next;
         else if (restart)            fault_code <= FAULT_NONE;

         // Acquisition is the timing reference for the first measured interval.
         if (state_next != ST_TRACK) begin
            per_cnt      <= '0;
            period_valid <= 1'b0;
            step_seen    <= 1'b0;
         end else if (acquire || do_step) begin
            per_cnt <= PER_W'(1);
            if (do_step) begin
               step_period  <= per_cnt;
               step_seen    <= 1'b1;
               period_valid <= step_seen;
            end
         end else if (per_cnt != PER_MAX) begin
            per_cnt <= per_cnt + PER_W'(1);
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_stepper_phase_monitor.sv
// Testbench for stepper_phase_monitor: scenario tasks and a random walk checked
// against a pattern-level model of the monitor's behaviour.
`default_nettype none

module tb_stepper_phase_monitor;

   localparam logic [3:0] PH  [8] = '{4'b0100, 4'b0101, 4'b0001, 4'b1001,
                                      4'b1000, 4'b1010, 4'b0010, 4'b0110};
   localparam logic [3:0] ILL [7] = '{4'b1111, 4'b0011, 4'b1100, 4'b0111,
                                      4'b1011, 4'b1101, 4'b1110};

   logic        clk = 1'b0;
   logic        resetn;
   logic [3:0]  coil;
   logic        pos_clear;
   logic        fault_clear;
   logic [31:0] position;
   logic        step_pulse;
   logic        step_dir;
   logic [23:0] step_period;
   logic        period_valid;
   logic        fault;
   logic [1:0]  fault_code;
   logic        tracking;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int pulses = 0;

   // model state: 0 idle, 1 track, 2 fault
   int          m_state;
   int          m_idx;
   int          m_pulses = 0;
   int          m_ref_t;
   int          m_period;
   logic [31:0] m_pos;
   logic        m_dir;
   logic [1:0]  m_code;
   logic        m_pvalid;
   logic        m_seen;
   logic        m_has_acc;
   logic [3:0]  m_acc;
   logic [3:0]  cur_coil;

   logic [37:0] obs_state;
   assign obs_state = {position, step_dir, fault, fault_code, tracking, period_valid};

   stepper_phase_monitor dut (
      .CLK50MHZ     (clk),
      .resetn       (resetn),
      .coil         (coil),
      .pos_clear    (pos_clear),
      .fault_clear  (fault_clear),
      .position     (position),
      .step_pulse   (step_pulse),
      .step_dir     (step_dir),
      .step_period  (step_period),
      .period_valid (period_valid),
      .fault        (fault),
      .fault_code   (fault_code),
      .tracking     (tracking)
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc++;
   always @(negedge clk) if (step_pulse === 1'b1) pulses++;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   function automatic int pat_index(input logic [3:0] p);
      for (int i = 0; i < 8; i++) if (PH[i] == p) return i;
      return -1;
   endfunction

   function automatic logic [37:0] exp_state();
      return {m_pos, m_dir, (m_state == 2), m_code, (m_state == 1), m_pvalid};
   endfunction

   task automatic m_reset();
      m_state = 0; m_idx = 0; m_ref_t = 0; m_period = 0;
      m_pos = '0; m_dir = 1'b0; m_code = 2'b00; m_pvalid = 1'b0;
      m_seen = 1'b0; m_has_acc = 1'b0; m_acc = 4'b0000;
   endtask

   // Effect of pattern p being held long enough to be accepted, applied at cycle t.
   task automatic m_apply(input logic [3:0] p, input int t);
      int i;
      int d;
      if (m_has_acc && p == m_acc) return;
      m_acc = p;
      m_has_acc = 1'b1;
      i = pat_index(p);
      if (m_state == 0) begin
         if (i >= 0) begin
            m_state = 1; m_idx = i; m_ref_t = t; m_seen = 1'b0;
         end else if (p != 4'b0000) begin
            m_state = 2; m_code = 2'b01;
         end
      end else if (m_state == 1) begin
         if (p == 4'b0000) begin
            m_state = 0; m_pvalid = 1'b0;
         end else if (i < 0) begin
            m_state = 2; m_code = 2'b01; m_pvalid = 1'b0;
         end else begin
            d = (i - m_idx + 8) % 8;
            if (d == 1 || d == 7) begin
               m_pulses++;
               m_dir = (d == 7);
               m_pos = (d == 1) ? m_pos + 32'd1 : m_pos - 32'd1;
               m_period = t - m_ref_t;
               m_ref_t = t;
               if (m_seen) m_pvalid = 1'b1;
               m_seen = 1'b1;
               m_idx = i;
            end else begin
               m_state = 2; m_code = 2'b10; m_pvalid = 1'b0;
            end
         end
      end
   endtask

   task automatic apply(input logic [3:0] p, input int hold);
      coil = p;
      cur_coil = p;
      m_apply(p, cyc);
      repeat (hold) @(posedge clk);
      #1;
   endtask

   task automatic pulse_fault_clear();
      fault_clear = 1'b1;
      @(posedge clk); #1;
      fault_clear = 1'b0;
      if (m_state == 2) begin
         m_state = 0; m_code = 2'b00; m_has_acc = 1'b0;
         m_apply(cur_coil, cyc);
      end
      repeat (10) @(posedge clk);
      #1;
   endtask

   task automatic pulse_pos_clear();
      pos_clear = 1'b1;
      @(posedge clk); #1;
      pos_clear = 1'b0;
      m_pos = '0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0; coil = 4'b0000; cur_coil = 4'b0000;
      pos_clear = 1'b0; fault_clear = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({obs_state, step_pulse, step_period} !== 63'd0) begin
         errors++;
         $display("FAIL reset_values: got state=%h pulse=%b period=%0d, expected all zero",
                  obs_state, step_pulse, step_period);
      end
      resetn = 1'b1;
      m_reset();
      m_apply(4'b0000, cyc);
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (obs_state !== exp_state()) begin
         errors++;
         $display("FAIL reset_idle: got %h expected %h", obs_state, exp_state());
      end
   endtask

   task automatic test_forward();
      int p0;
      p0 = pulses;
      apply(PH[0], 20);
      for (int i = 1; i <= 8; i++) begin
         apply(PH[i % 8], 20);
         checks++;
         if (obs_state !== exp_state()) begin
            errors++;
            $display("FAIL forward_step%0d: got %h expected %h", i, obs_state, exp_state());
         end
      end
      checks++;
      if (position !== 32'd8 || step_period !== 24'd20 || step_dir !== 1'b0 || period_valid !== 1'b1) begin
         errors++;
         $display("FAIL forward_totals: got pos=%0d period=%0d dir=%b pv=%b, expected 8 20 0 1",
                  position, step_period, step_dir, period_valid);
      end
      checks++;
      if (pulses - p0 !== 8) begin
         errors++;
         $display("FAIL forward_pulses: got %0d expected 8", pulses - p0);
      end
   endtask

   task automatic test_reverse();
      logic [31:0] base;
      apply(PH[1], 12);
      apply(PH[2], 12);
      apply(PH[3], 12);
      base = m_pos;
      apply(PH[2], 12);
      apply(PH[1], 12);
      checks++;
      if (position !== base - 32'd2 || step_dir !== 1'b1 || fault !== 1'b0) begin
         errors++;
         $display("FAIL reverse: got pos=%0d dir=%b fault=%b, expected pos=%0d dir=1 fault=0",
                  position, step_dir, fault, base - 32'd2);
      end
      checks++;
      if (obs_state !== exp_state()) begin
         errors++;
         $display("FAIL reverse_state: got %h expected %h", obs_state, exp_state());
      end
   endtask

   task automatic test_skip();
      logic [31:0] base;
      int p0;
      apply(PH[0], 12);
      base = m_pos;
      p0 = pulses;
      apply(PH[3], 12);
      checks++;
      if (fault !== 1'b1 || fault_code !== 2'b10 || position !== base) begin
         errors++;
         $display("FAIL skip_fault: got fault=%b code=%b pos=%0d, expected 1 10 %0d",
                  fault, fault_code, position, base);
      end
      apply(PH[4], 12);
      checks++;
      if (pulses !== p0 || position !== base || fault !== 1'b1) begin
         errors++;
         $display("FAIL skip_ignored: got pulses=%0d pos=%0d fault=%b, expected %0d %0d 1",
                  pulses, position, fault, p0, base);
      end
      pulse_fault_clear();
      checks++;
      if (tracking !== 1'b1 || fault !== 1'b0 || fault_code !== 2'b00 || pulses !== p0) begin
         errors++;
         $display("FAIL skip_clear: got trk=%b fault=%b code=%b pulses=%0d, expected 1 0 00 %0d",
                  tracking, fault, fault_code, pulses, p0);
      end
   endtask

   task automatic test_illegal();
      int p0;
      apply(4'b1111, 10);
      checks++;
      if (fault !== 1'b1 || fault_code !== 2'b01) begin
         errors++;
         $display("FAIL illegal_fault: got fault=%b code=%b, expected 1 01", fault, fault_code);
      end
      apply(PH[5], 12);
      pulse_fault_clear();
      p0 = pulses;
      coil = 4'b1111;
      repeat (2) @(posedge clk);
      #1;
      apply(PH[6], 12);
      checks++;
      if (fault !== 1'b0 || pulses !== p0 + 1 || obs_state !== exp_state()) begin
         errors++;
         $display("FAIL glitch: got fault=%b pulses=%0d state=%h, expected 0 %0d %h",
                  fault, pulses, obs_state, p0 + 1, exp_state());
      end
   endtask

   task automatic test_pos_clear();
      coil = PH[7];
      cur_coil = PH[7];
      m_apply(PH[7], cyc);
      repeat (6) @(posedge clk);
      #1;
      pos_clear = 1'b1;
      @(posedge clk); #1;
      pos_clear = 1'b0;
      m_pos = '0;
      checks++;
      if (step_pulse !== 1'b1 || position !== 32'd0 || step_dir !== 1'b0) begin
         errors++;
         $display("FAIL pos_clear_step: got pulse=%b pos=%0d dir=%b, expected 1 0 0",
                  step_pulse, position, step_dir);
      end
      repeat (8) @(posedge clk);
      #1;
      checks++;
      if (obs_state !== exp_state()) begin
         errors++;
         $display("FAIL pos_clear_state: got %h expected %h", obs_state, exp_state());
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 60; n++) begin
         int r;
         int h;
         int ci;
         r  = $urandom_range(0, 99);
         h  = $urandom_range(9, 24);
         ci = pat_index(cur_coil);
         if (ci < 0) ci = $urandom_range(0, 7);
         if (m_state == 2 && r < 50)  pulse_fault_clear();
         else if (r < 50)             apply(PH[(ci + 1) % 8], h);
         else if (r < 70)             apply(PH[(ci + 7) % 8], h);
         else if (r < 75)             apply(4'b0000, h);
         else if (r < 80)             apply(ILL[$urandom_range(0, 6)], h);
         else if (r < 85)             apply(PH[(ci + $urandom_range(2, 6)) % 8], h);
         else if (r < 90) begin
            coil = 4'b1111;
            repeat (2) @(posedge clk);
            #1;
            apply(PH[(ci + 1) % 8], h);
         end
         else if (r < 95)             pulse_pos_clear();
         else                         pulse_fault_clear();
         checks++;
         if (obs_state !== exp_state() || pulses !== m_pulses) begin
            errors++;
            $display("FAIL random%0d: got %h pulses=%0d expected %h pulses=%0d",
                     n, obs_state, pulses, exp_state(), m_pulses);
         end
         if (m_pvalid) begin
            checks++;
            if (step_period !== m_period[23:0]) begin
               errors++;
               $display("FAIL random%0d_period: got %0d expected %0d", n, step_period, m_period);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int p0;
      int ci;
      if (m_state == 2) pulse_fault_clear();
      ci = pat_index(cur_coil);
      if (ci < 0) ci = 0;
      coil = PH[(ci + 1) % 8];
      repeat (4) @(posedge clk);
      #3;
      resetn = 1'b0;
      #1;
      checks++;
      if ({obs_state, step_pulse, step_period} !== 63'd0) begin
         errors++;
         $display("FAIL reset_mid: got state=%h pulse=%b period=%0d, expected all zero",
                  obs_state, step_pulse, step_period);
      end
      coil = 4'b0000;
      cur_coil = 4'b0000;
      repeat (3) @(posedge clk);
      #1;
      resetn = 1'b1;
      m_reset();
      p0 = pulses;
      apply(4'b0000, 20);
      checks++;
      if (tracking !== 1'b0 || obs_state !== exp_state()) begin
         errors++;
         $display("FAIL reset_mid_idle: got %h trk=%b expected %h trk=0",
                  obs_state, tracking, exp_state());
      end
      apply(PH[2], 12);
      checks++;
      if (tracking !== 1'b1 || pulses !== p0 || position !== 32'd0) begin
         errors++;
         $display("FAIL reset_mid_acquire: got trk=%b pulses=%0d pos=%0d, expected 1 %0d 0",
                  tracking, pulses, position, p0);
      end
   endtask

   initial begin
      test_reset();
      test_forward();
      test_reverse();
      test_skip();
      test_illegal();
      test_pos_clear();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
